// File: rtl/bp_gshare_spec.sv
// Speculative-history gshare predictor with an in-flight checkpoint FIFO; optional BP_GSHARE_STATS_EN adds resolve/mispredict counters.
// Latency: prediction and target are combinational from fetch; training, history and recovery update on the next clk_i edge.
// Backpressure: fetch_ready_o drops while the checkpoint FIFO is full; conditional branches are then not accepted and predict not-taken.

module bp_gshare_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             push_vld,
    input  logic [Width-1:0] push_dat,
    input  logic             pop_vld,
    output logic [Width-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW:0]    wr_ptr;
    logic [PtrW:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full    = (wr_ptr[PtrW] != rd_ptr[PtrW]) && (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push_vld && !full && !clr;
    assign do_pop  = pop_vld && !empty && !clr;
    assign pop_dat = mem[rd_ptr[PtrW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[PtrW-1:0]] <= push_dat;
    end
endmodule

module bp_gshare_spec #(
    parameter int CTableSize    = 1024,
    parameter int CounterLen    = 2,
    parameter int GHRLen        = 10,
    parameter int InflightDepth = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    output logic        predict_branch_taken_o,
    output logic [31:0] predict_branch_pc_o,
    input  logic        ex_br_valid_i,
    input  logic        ex_br_taken_i,
    output logic        ex_mispredict_o,
    input  logic        flush_i
`ifdef BP_GSHARE_STATS_EN
    ,
    output logic [31:0] stat_resolved_o,
    output logic [31:0] stat_mispredict_o
`endif
);
    localparam int IdxW = $clog2(CTableSize);
    localparam logic [CounterLen-1:0] CtrInit = {1'b0, {(CounterLen-1){1'b1}}};

    typedef struct packed {
        logic [IdxW-1:0]   idx;
        logic              pred;
        logic [GHRLen-1:0] ghr;
    } entry_t;

    logic [31:0]           instr;
    logic                  instr_b, instr_j, instr_cj, instr_cb;
    logic                  is_cond, is_jump;
    logic [31:0]           imm_b, imm_j, imm_cj, imm_cb, branch_imm;

    logic [GHRLen-1:0]     spec_ghr, spec_ghr_nxt;
    logic [GHRLen-1:0]     commit_ghr, commit_ghr_nxt;
    logic [IdxW-1:0]       ghr_hash, pred_idx;
    logic [CounterLen-1:0] ctr [CTableSize];
    logic [CounterLen-1:0] train_rd, train_wd;
    logic                  pred_taken;

    entry_t                push_ent, head;
    logic                  fifo_full, fifo_empty, fifo_clr;
    logic                  push_vld, pop_vld, mispredict;
    logic                  unused_bits;

    // Decode
    assign instr    = fetch_rdata_i;
    assign instr_b  = (instr[6:0] == 7'b1100011);
    assign instr_j  = (instr[6:0] == 7'b1101111);
    assign instr_cj = (instr[1:0] == 2'b01) && ((instr[15:13] == 3'b101) || (instr[15:13] == 3'b001));
    assign instr_cb = (instr[1:0] == 2'b01) && ((instr[15:13] == 3'b110) || (instr[15:13] == 3'b111));
    assign is_cond  = instr_b || instr_cb;
    assign is_jump  = instr_j || instr_cj;

    assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_cj = {{21{instr[12]}}, instr[8], instr[10:9], instr[6], instr[7], instr[2],
                     instr[11], instr[5:3], 1'b0};
    assign imm_cb = {{24{instr[12]}}, instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};

    always_comb begin
        branch_imm = imm_b;
        if (instr_j)       branch_imm = imm_j;
        else if (instr_cj) branch_imm = imm_cj;
        else if (instr_cb) branch_imm = imm_cb;
    end

    assign predict_branch_pc_o = fetch_pc_i + branch_imm;

    // History folded onto the index width: truncated if longer, zero-extended if shorter.
    if (GHRLen >= IdxW) begin : g_hash_trunc
        assign ghr_hash = spec_ghr[IdxW-1:0];
    end else begin : g_hash_ext
        assign ghr_hash = {{(IdxW-GHRLen){1'b0}}, spec_ghr};
    end

    assign pred_idx   = fetch_pc_i[IdxW+1:2] ^ ghr_hash;
    assign pred_taken = ctr[pred_idx][CounterLen-1];

    assign fetch_ready_o          = !fifo_full;
    assign predict_branch_taken_o = fetch_valid_i && (is_jump || (is_cond && fetch_ready_o && pred_taken));

    // Checkpoint FIFO
    assign push_vld      = fetch_valid_i && fetch_ready_o && is_cond;
    assign push_ent.idx  = pred_idx;
    assign push_ent.pred = pred_taken;
    assign push_ent.ghr  = spec_ghr;

    assign pop_vld         = ex_br_valid_i && !fifo_empty;
    assign mispredict      = pop_vld && (ex_br_taken_i != head.pred);
    assign ex_mispredict_o = mispredict;
    assign fifo_clr        = mispredict || flush_i;

    bp_gshare_fifo #(
        .Width ($bits(entry_t)),
        .Depth (InflightDepth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr      (fifo_clr),
        .push_vld (push_vld),
        .push_dat (push_ent),
        .pop_vld  (pop_vld),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Training always uses the index captured at prediction time.
    assign train_rd = ctr[head.idx];

    always_comb begin
        train_wd = train_rd;
        if (ex_br_taken_i) begin
            if (train_rd != {CounterLen{1'b1}}) train_wd = train_rd + 1'b1;
        end else begin
            if (train_rd != '0) train_wd = train_rd - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < CTableSize; i++) ctr[i] <= CtrInit;
        end else if (pop_vld) begin
            ctr[head.idx] <= train_wd;
        end
    end

    // History update: recovery beats flush beats speculative push.
    assign commit_ghr_nxt = pop_vld ? {commit_ghr[GHRLen-2:0], ex_br_taken_i} : commit_ghr;

    always_comb begin
        spec_ghr_nxt = spec_ghr;
        if (mispredict)    spec_ghr_nxt = {head.ghr[GHRLen-2:0], ex_br_taken_i};
        else if (flush_i)  spec_ghr_nxt = commit_ghr_nxt;
        else if (push_vld) spec_ghr_nxt = {spec_ghr[GHRLen-2:0], pred_taken};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_ghr   <= '0;
            commit_ghr <= '0;
        end else begin
            spec_ghr   <= spec_ghr_nxt;
            commit_ghr <= commit_ghr_nxt;
        end
    end

`ifdef BP_GSHARE_STATS_EN
    logic [31:0] stat_resolved_q, stat_mispredict_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_resolved_q   <= '0;
            stat_mispredict_q <= '0;
        end else begin
            if (pop_vld)    stat_resolved_q   <= stat_resolved_q + 32'd1;
            if (mispredict) stat_mispredict_q <= stat_mispredict_q + 32'd1;
        end
    end

    assign stat_resolved_o   = stat_resolved_q;
    assign stat_mispredict_o = stat_mispredict_q;
`endif

    assign unused_bits = ^{fetch_pc_i[31:IdxW+2], fetch_pc_i[1:0], head.ghr[GHRLen-1]};
endmodule

// File: tb/tb_bp_gshare_spec.sv
// Directed bench for bp_gshare_spec: a behavioural predictor model feeds a scoreboard of expected outputs per cycle.
module tb_bp_gshare_spec;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] fetch_rdata_i, fetch_pc_i;
    logic        fetch_valid_i, fetch_ready_o;
    logic        predict_branch_taken_o;
    logic [31:0] predict_branch_pc_o;
    logic        ex_br_valid_i, ex_br_taken_i, ex_mispredict_o, flush_i;

    int errors = 0;
    int checks = 0;

    bp_gshare_spec dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .fetch_rdata_i          (fetch_rdata_i),
        .fetch_pc_i             (fetch_pc_i),
        .fetch_valid_i          (fetch_valid_i),
        .fetch_ready_o          (fetch_ready_o),
        .predict_branch_taken_o (predict_branch_taken_o),
        .predict_branch_pc_o    (predict_branch_pc_o),
        .ex_br_valid_i          (ex_br_valid_i),
        .ex_br_taken_i          (ex_br_taken_i),
        .ex_mispredict_o        (ex_mispredict_o),
        .flush_i                (flush_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [9:0] idx;
        logic       pred;
        logic [9:0] ghr;
    } ent_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic        chk_pc;
        logic        ready;
        logic        misp;
    } exp_t;

    int         m_ctr [1024];
    logic [9:0] m_sghr, m_cghr;
    ent_t       m_q [$];
    exp_t       sb [$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd1, 5'd2, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_cj(input logic [31:0] imm, input logic [2:0] f3);
        return {16'hA5A5, f3, imm[11], imm[4], imm[9:8], imm[10], imm[6], imm[7], imm[3:1], imm[5], 2'b01};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [31:0] imm, input logic [2:0] f3);
        return {16'hA5A5, f3, imm[8], imm[4:3], 3'd1, imm[7:6], imm[2:1], imm[5], 2'b01};
    endfunction

    // PC whose gshare index equals tidx under the current speculative history.
    function automatic logic [31:0] pc_for(input logic [9:0] tidx);
        return 32'h8000_0000 | {20'h0, tidx ^ m_sghr, 2'b00};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_ctr[i] = 1;
        m_sghr = '0;
        m_cghr = '0;
        m_q.delete();
        sb.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind: 0 = not a branch, 1 = conditional, 2 = jump
    task automatic step(input logic fv, input logic [31:0] ins, input logic [31:0] pc, input int kind,
                        input logic [31:0] tgt, input logic bv, input logic bt, input logic fl);
        exp_t       e, g;
        ent_t       h;
        logic [9:0] idx;
        logic       pred, full, pop, push, misp;
        fetch_valid_i = fv;
        fetch_rdata_i = ins;
        fetch_pc_i    = pc;
        ex_br_valid_i = bv;
        ex_br_taken_i = bt;
        flush_i       = fl;
        full = (m_q.size() == 4);
        idx  = pc[11:2] ^ m_sghr;
        pred = (m_ctr[idx] >= 2);
        pop  = bv && (m_q.size() != 0);
        misp = 1'b0;
        if (pop) misp = (bt != m_q[0].pred);
        push = fv && (kind == 1) && !full;
        e.taken  = fv && ((kind == 2) || ((kind == 1) && !full && pred));
        e.pc     = tgt;
        e.chk_pc = (kind != 0);
        e.ready  = !full;
        e.misp   = misp;
        sb.push_back(e);
        @(negedge clk_i);
        g = sb.pop_front();
        chk("taken", {31'd0, predict_branch_taken_o}, {31'd0, g.taken});
        chk("ready", {31'd0, fetch_ready_o}, {31'd0, g.ready});
        chk("mispredict", {31'd0, ex_mispredict_o}, {31'd0, g.misp});
        if (g.chk_pc) chk("target", predict_branch_pc_o, g.pc);
        @(posedge clk_i);
        if (pop) begin
            h = m_q.pop_front();
            if (bt && m_ctr[h.idx] < 3) m_ctr[h.idx]++;
            else if (!bt && m_ctr[h.idx] > 0) m_ctr[h.idx]--;
            m_cghr = {m_cghr[8:0], bt};
        end
        if (misp) begin
            m_sghr = {h.ghr[8:0], bt};
            m_q.delete();
        end else if (fl) begin
            m_q.delete();
            m_sghr = m_cghr;
        end else if (push) begin
            m_q.push_back({idx, pred, m_sghr});
            m_sghr = {m_sghr[8:0], pred};
        end
        #1;
    endtask

    task automatic fetch_cond(input logic [9:0] tidx);
        logic [31:0] pc;
        pc = pc_for(tidx);
        step(1'b1, enc_b(32'h40, 3'b001), pc, 1, pc + 32'h40, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve_dir(input logic bt);
        step(1'b0, NOP, 32'h0, 0, 32'h0, 1'b1, bt, 1'b0);
    endtask

    task automatic resolve(input bit correct);
        logic bt;
        bt = 1'b0;
        if (m_q.size() != 0) bt = correct ? m_q[0].pred : !m_q[0].pred;
        resolve_dir(bt);
    endtask

    task automatic async_reset();
        fetch_valid_i = 1'b0;
        ex_br_valid_i = 1'b0;
        flush_i       = 1'b0;
        rst_ni        = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", {31'd0, fetch_ready_o}, 32'd1);
        chk("rst_taken", {31'd0, predict_branch_taken_o}, 32'd0);
        chk("rst_misp", {31'd0, ex_mispredict_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        fetch_valid_i = 1'b0;
        fetch_rdata_i = NOP;
        fetch_pc_i    = '0;
        ex_br_valid_i = 1'b0;
        ex_br_taken_i = 1'b0;
        flush_i       = 1'b0;
        rst_ni        = 1'b1;
        #2;
        async_reset();

        // BEQ at 0x100 (+0x20): weak-NT counter predicts not taken; actual taken mispredicts.
        step(1'b1, enc_b(32'h20, 3'b000), 32'h100, 1, 32'h120, 1'b0, 1'b0, 1'b0);
        resolve_dir(1'b1);
        // History is now 0x001, so 0x104 hashes back onto the trained counter 0x040.
        step(1'b1, enc_b(32'h20, 3'b000), 32'h104, 1, 32'h124, 1'b0, 1'b0, 1'b0);
        resolve(1);

        // Jumps: always taken, never pushed, history untouched.
        step(1'b1, enc_j(32'hFFFF_FFF0), 32'h200, 2, 32'h1F0, 1'b0, 1'b0, 1'b0);
        step(1'b1, enc_j(32'h000F_FFFE), 32'h1000, 2, 32'h0010_0FFE, 1'b0, 1'b0, 1'b0);
        step(1'b1, enc_cj(32'h3A6, 3'b101), 32'h300, 2, 32'h6A6, 1'b0, 1'b0, 1'b0);
        step(1'b1, enc_cj(32'hFFFF_F800, 3'b001), 32'h400, 2, 32'hFFFF_FC00, 1'b0, 1'b0, 1'b0);
        step(1'b0, enc_j(32'h40), 32'h500, 2, 32'h540, 1'b0, 1'b0, 1'b0);
        step(1'b1, NOP, 32'h600, 0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Compressed and wide-immediate conditional branches.
        pc = pc_for(10'h040);
        step(1'b1, enc_cb(32'hFFFF_FF00, 3'b110), pc, 1, pc - 32'h100, 1'b0, 1'b0, 1'b0);
        pc = pc_for(10'h040);
        step(1'b1, enc_cb(32'hAE, 3'b111), pc, 1, pc + 32'hAE, 1'b0, 1'b0, 1'b0);
        pc = pc_for(10'h123);
        step(1'b1, enc_b(32'hFFFF_F000, 3'b001), pc, 1, pc - 32'h1000, 1'b0, 1'b0, 1'b0);
        resolve(1);
        resolve(1);
        resolve(0);
        pc = pc_for(10'h124);
        step(1'b1, enc_b(32'hFFE, 3'b101), pc, 1, pc + 32'hFFE, 1'b0, 1'b0, 1'b0);
        resolve(1);

        // Fill the FIFO; a fifth branch onto a taken counter is refused and predicted NT.
        for (int i = 0; i < 4; i++) fetch_cond(10'h100 + 10'(i));
        fetch_cond(10'h040);
        resolve(1);
        pc = pc_for(10'h104);
        step(1'b1, enc_b(32'h40, 3'b001), pc, 1, pc + 32'h40, 1'b1, m_q[0].pred, 1'b0);
        fetch_cond(10'h105);
        fetch_cond(10'h106);
        for (int i = 0; i < 4; i++) resolve(1);

        // Oldest of three mispredicts: recovery empties the FIFO, younger never train.
        fetch_cond(10'h040);
        fetch_cond(10'h201);
        fetch_cond(10'h202);
        resolve(0);
        resolve_dir(1'b1);
        fetch_cond(10'h201);
        fetch_cond(10'h202);
        fetch_cond(10'h203);
        fetch_cond(10'h204);
        fetch_cond(10'h205);
        for (int i = 0; i < 4; i++) resolve(1);

        // Saturation at max.
        for (int i = 0; i < 4; i++) begin
            fetch_cond(10'h155);
            resolve_dir(1'b1);
        end
        fetch_cond(10'h155);
        resolve_dir(1'b0);
        fetch_cond(10'h155);
        resolve_dir(1'b0);
        fetch_cond(10'h155);
        resolve_dir(1'b0);

        // Saturation at zero.
        for (int i = 0; i < 3; i++) begin
            fetch_cond(10'h2AA);
            resolve_dir(1'b0);
        end
        fetch_cond(10'h2AA);
        resolve_dir(1'b1);
        fetch_cond(10'h2AA);
        resolve_dir(1'b1);
        fetch_cond(10'h2AA);
        resolve(1);

        // Flush with a same-cycle correct pop, then refill to prove the FIFO emptied.
        fetch_cond(10'h040);
        fetch_cond(10'h300);
        step(1'b0, NOP, 32'h0, 0, 32'h0, 1'b1, m_q[0].pred, 1'b1);
        for (int i = 0; i < 5; i++) fetch_cond(10'h040 + 10'(i));
        for (int i = 0; i < 4; i++) resolve(1);

        // Flush beats a same-cycle push; resolves on an empty FIFO are ignored.
        fetch_cond(10'h310);
        pc = pc_for(10'h040);
        step(1'b1, enc_b(32'h40, 3'b001), pc, 1, pc + 32'h40, 1'b0, 1'b0, 1'b1);
        resolve_dir(1'b1);
        resolve_dir(1'b0);
        fetch_cond(10'h040);
        resolve(1);

        // Asynchronous reset while the FIFO is full restores counters and history.
        for (int i = 0; i < 4; i++) fetch_cond(10'h040);
        #2;
        async_reset();
        fetch_cond(10'h040);
        for (int i = 0; i < 4; i++) fetch_cond(10'h060 + 10'(i));
        resolve(0);
        resolve_dir(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
